// File: rtl/lsu_out_periph.sv
// lsu_out_periph: LEDR/HEX/LCD output register bank with lane writes, registered read-back and a paced LCD enable pulse
module lsu_out_periph #(
  parameter int LCD_SETUP = 2,
  parameter int LCD_PULSE = 4,
  parameter int LCD_HOLD  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_sel,
  input  logic [12:0] i_addr,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_rvalid,
  output logic        o_stall,
  output logic        o_err,
  output logic [31:0] o_ledr,
  output logic [31:0] o_hex,
  output logic [31:0] o_lcd_data,
  output logic        o_lcd_en
);
  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] ledr_q, ledr_d, hex_q, hex_d, lcd_q, lcd_d, rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d, err_q, err_d, lcd_en_q, lcd_en_d;
  logic [1:0]  idx, ofs;
  logic        hit, acc, bad, wr_ok, rd_ok, lcd_go, unused_addr;
  logic [3:0]  be;
  logic [31:0] mask, wd, rsel, rsh;

  assign unused_addr = ^i_addr[12:4];
  assign idx     = i_addr[3:2];
  assign ofs     = i_addr[1:0];
  assign hit     = i_req && i_sel == 2'b01;
  assign o_stall = hit && i_wr && idx == 2'b11 && state_q != IDLE;
  assign acc     = hit && !o_stall;
  assign bad     = i_size == 2'b11 || idx == 2'b01 || (i_size == 2'b01 && ofs[0]) ||
                   (i_size == 2'b10 && ofs != 2'b00);
  assign wr_ok   = acc && i_wr && !bad;
  assign rd_ok   = acc && !i_wr && !bad;
  assign lcd_go  = wr_ok && idx == 2'b11;
  assign be      = i_size == 2'b00 ? 4'b0001 << ofs : i_size == 2'b01 ? (ofs[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign mask    = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign wd      = i_size == 2'b00 ? {4{i_wdata[7:0]}} : i_size == 2'b01 ? {2{i_wdata[15:0]}} : i_wdata;
  assign rsel    = idx == 2'b00 ? ledr_q : idx == 2'b10 ? hex_q : lcd_q;
  assign rsh     = rsel >> {ofs, 3'b000};

  always_comb begin
    ledr_d   = wr_ok && idx == 2'b00 ? (ledr_q & ~mask) | (wd & mask) : ledr_q;
    hex_d    = wr_ok && idx == 2'b10 ? (hex_q & ~mask) | (wd & mask) : hex_q;
    lcd_d    = lcd_go ? (lcd_q & ~mask) | (wd & mask) : lcd_q;
    rdata_d  = !rd_ok ? rdata_q : i_size == 2'b00 ? {24'b0, rsh[7:0]} :
               i_size == 2'b01 ? {16'b0, rsh[15:0]} : rsh;
    rvalid_d = rd_ok;
    err_d    = acc && bad;
  end

  // one down-counter, reloaded on every state entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - 8'd1;
    if (state_q == IDLE) begin
      cnt_d = cnt_q;
      if (lcd_go) begin
        state_d = SETUP;
        cnt_d   = 8'(LCD_SETUP - 1);
      end
    end else if (cnt_q == 8'd0) begin
      state_d = state_q == SETUP ? PULSE : state_q == PULSE ? HOLD : IDLE;
      cnt_d   = state_q == SETUP ? 8'(LCD_PULSE - 1) : state_q == PULSE ? 8'(LCD_HOLD - 1) : 8'd0;
    end
    lcd_en_d = state_d == PULSE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ledr_q   <= '0;
      hex_q    <= '0;
      lcd_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      lcd_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ledr_q   <= ledr_d;
      hex_q    <= hex_d;
      lcd_q    <= lcd_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      lcd_en_q <= lcd_en_d;
    end
  end

  assign o_rdata    = rdata_q;
  assign o_rvalid   = rvalid_q;
  assign o_err      = err_q;
  assign o_ledr     = ledr_q;
  assign o_hex      = hex_q;
  assign o_lcd_data = lcd_q;
  assign o_lcd_en   = lcd_en_q;
endmodule
